seq_detect_param: RTL and testbench

Parametrised serial sequence detector and successor to the fixed-pattern `net` detector. It samples a 1-bit stream on `clk` and compares the last PAT_LEN bits against a runtime-loadable pattern. It raises a one-cycle `match` pulse, supports overlapping or non-overlapping detection, and keeps a saturating match counter. It sits directly on a serial input line, in the same position as the existing detector driven by the Clock14 clock.

---
 rtl/seq_pkg.sv | 12 +
 rtl/seq_hist_shift.sv | 39 +++
 rtl/seq_detect_param.sv | 73 +++++++
 tb/tb_seq_detect_param.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package seq_pkg;

  localparam int unsigned MAX_PAT_LEN = 32;
  localparam logic [3:0]  DEF_PAT_4   = 4'b1001;

  // Width of a counter able to hold 0..pat_len inclusive.
  function automatic int unsigned fill_w(input int unsigned pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/seq_hist_shift.sv
// Serial history shift register plus saturating fill count (EMPTY/FILLING/PRIMED).
module seq_hist_shift
  import seq_pkg::*;
#(
  parameter int unsigned PAT_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        shift,
  input  logic                        clr,
  input  logic                        din,
  output logic [PAT_LEN-1:0]          nxt_hist,
  output logic [fill_w(PAT_LEN)-1:0]  fill,
  output logic [fill_w(PAT_LEN)-1:0]  nxt_fill
);

  localparam int unsigned    FW   = fill_w(PAT_LEN);
  localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist;

  // Post-shift view, used by the parent to detect a match on the sampling edge.
  always_comb begin
    nxt_hist = {hist[PAT_LEN-2:0], din};
    nxt_fill = (fill == FULL) ? FULL : fill + FW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else begin
      if (shift) hist <= nxt_hist;
      if (clr)        fill <= '0;
      else if (shift) fill <= nxt_fill;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-loadable serial pattern detector with registered match pulse and saturating match counter.
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int unsigned         PAT_LEN = 4,
  parameter bit                  OVERLAP = 1'b1,
  parameter int unsigned         CNT_W   = 8,
  parameter logic [PAT_LEN-1:0]  RST_PAT = PAT_LEN'(DEF_PAT_4)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        din,
  input  logic                        load,
  input  logic [PAT_LEN-1:0]          pat_in,
  input  logic                        clr_cnt,
  output logic                        match,
  output logic [CNT_W-1:0]            match_cnt,
  output logic                        cnt_sat,
  output logic [fill_w(PAT_LEN)-1:0]  fill
);

  localparam int unsigned FW = fill_w(PAT_LEN);

  logic [PAT_LEN-1:0] pat;
  logic [PAT_LEN-1:0] nxt_hist;
  logic [FW-1:0]      nxt_fill;
  logic               shift;
  logic               hit;
  logic               hist_clr;
  logic [CNT_W-1:0]   cnt_inc;

  // load takes priority over sampling; a non-overlapping match empties the history.
  always_comb begin
    shift    = en & ~load;
    hit      = shift && (nxt_fill == FW'(PAT_LEN)) && (nxt_hist == pat);
    hist_clr = load | (hit & ~OVERLAP);
    cnt_inc  = match_cnt + CNT_W'(1);
  end

  seq_hist_shift #(
    .PAT_LEN (PAT_LEN)
  ) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift    (shift),
    .clr      (hist_clr),
    .din      (din),
    .nxt_hist (nxt_hist),
    .fill     (fill),
    .nxt_fill (nxt_fill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat       <= RST_PAT;
      match     <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      if (load) pat <= pat_in;
      match <= hit;
      if (clr_cnt) begin
        match_cnt <= '0;
        cnt_sat   <= 1'b0;
      end else if (hit && (match_cnt != '1)) begin
        match_cnt <= cnt_inc;
        if (cnt_inc == '1) cnt_sat <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param across four parameter sets.
module tb_seq_detect_param;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       din;
  logic       load;
  logic       clr_cnt;
  logic [3:0] pat_in4;
  logic [2:0] pat_in3;

  logic       m_d, sat_d;
  logic [7:0] cnt_d;
  logic [2:0] fill_d;
  logic       m_o, sat_o;
  logic [7:0] cnt_o;
  logic [1:0] fill_o;
  logic       m_n, sat_n;
  logic [7:0] cnt_n;
  logic [1:0] fill_n;
  logic       m_s, sat_s;
  logic [1:0] cnt_s;
  logic [2:0] fill_s;

  int n_checks = 0;
  int n_errors = 0;

  seq_detect_param u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .load(load), .pat_in(pat_in4),
    .clr_cnt(clr_cnt), .match(m_d), .match_cnt(cnt_d), .cnt_sat(sat_d), .fill(fill_d)
  );

  seq_detect_param #(.PAT_LEN(3), .OVERLAP(1'b1), .CNT_W(8), .RST_PAT(3'b101)) u_p3o (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .load(1'b0), .pat_in(pat_in3),
    .clr_cnt(clr_cnt), .match(m_o), .match_cnt(cnt_o), .cnt_sat(sat_o), .fill(fill_o)
  );

  seq_detect_param #(.PAT_LEN(3), .OVERLAP(1'b0), .CNT_W(8), .RST_PAT(3'b101)) u_p3n (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .load(1'b0), .pat_in(pat_in3),
    .clr_cnt(clr_cnt), .match(m_n), .match_cnt(cnt_n), .cnt_sat(sat_n), .fill(fill_n)
  );

  seq_detect_param #(.PAT_LEN(4), .OVERLAP(1'b1), .CNT_W(2), .RST_PAT(4'b1111)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .load(1'b0), .pat_in(pat_in4),
    .clr_cnt(clr_cnt), .match(m_s), .match_cnt(cnt_s), .cnt_sat(sat_s), .fill(fill_s)
  );

  // Clock14-style free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic d);
    en  = e;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; din = 1'b0; load = 1'b0; clr_cnt = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] s1, m1;
    logic [4:0] s2, mo, mn;
    logic [3:0] s5, m5;
    rst_n = 1'b1; en = 1'b0; din = 1'b0; load = 1'b0; clr_cnt = 1'b0;
    pat_in4 = 4'b0000; pat_in3 = 3'b000;

    // Test 1: reset state, default pattern 1001
    do_reset();
    check("rst_match", 32'(m_d), 0);
    check("rst_cnt",   32'(cnt_d), 0);
    check("rst_fill",  32'(fill_d), 0);
    check("rst_sat",   32'(sat_d), 0);
    s1 = 8'b10011100;
    m1 = 8'b00010000;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, s1[7-i]);
      check($sformatf("t1_match_b%0d", i+1), 32'(m_d), 32'(m1[7-i]));
      check($sformatf("t1_fill_b%0d", i+1), 32'(fill_d), (i + 1 > 4) ? 4 : i + 1);
    end
    check("t1_cnt", 32'(cnt_d), 1);
    check("t1_sat", 32'(sat_d), 0);

    // Test 2: PAT_LEN=3 pattern 101, overlapping vs non-overlapping
    do_reset();
    s2 = 5'b10101;
    mo = 5'b00101;
    mn = 5'b00100;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, s2[4-i]);
      check($sformatf("t2_ov_match_b%0d", i+1), 32'(m_o), 32'(mo[4-i]));
      check($sformatf("t2_nov_match_b%0d", i+1), 32'(m_n), 32'(mn[4-i]));
    end
    check("t2_ov_cnt",   32'(cnt_o), 2);
    check("t2_ov_fill",  32'(fill_o), 3);
    check("t2_ov_sat",   32'(sat_o), 0);
    check("t2_nov_cnt",  32'(cnt_n), 1);
    check("t2_nov_fill", 32'(fill_n), 2);
    check("t2_nov_sat",  32'(sat_n), 0);

    // Test 3: a disabled cycle is skipped, its din ignored
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("t3_dis_match", 32'(m_d), 0);
    check("t3_dis_fill",  32'(fill_d), 2);
    step(1'b1, 1'b0);
    check("t3_b3_match", 32'(m_d), 0);
    check("t3_b3_fill",  32'(fill_d), 3);
    step(1'b1, 1'b1);
    check("t3_b4_match", 32'(m_d), 1);
    check("t3_cnt",      32'(cnt_d), 1);

    // Test 4: CNT_W=2 saturation with pattern 1111, then clear
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1);
      check($sformatf("t4_match_b%0d", k), 32'(m_s), (k >= 4) ? 1 : 0);
      check($sformatf("t4_cnt_b%0d", k), 32'(cnt_s), (k < 4) ? 0 : ((k - 3 > 3) ? 3 : k - 3));
      check($sformatf("t4_sat_b%0d", k), 32'(sat_s), (k >= 6) ? 1 : 0);
    end
    clr_cnt = 1'b1;
    step(1'b0, 1'b0);
    clr_cnt = 1'b0;
    check("t4_clr_cnt",   32'(cnt_s), 0);
    check("t4_clr_sat",   32'(sat_s), 0);
    check("t4_clr_match", 32'(m_s), 0);
    // clear coinciding with a match: pulse still fires, counter stays zero
    clr_cnt = 1'b1;
    step(1'b1, 1'b1);
    clr_cnt = 1'b0;
    check("t4_clrhit_match", 32'(m_s), 1);
    check("t4_clrhit_cnt",   32'(cnt_s), 0);
    check("t4_clrhit_fill",  32'(fill_s), 4);

    // Test 5: load has priority over sampling and empties the history
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    load = 1'b1;
    pat_in4 = 4'b0110;
    step(1'b1, 1'b1);
    load = 1'b0;
    check("t5_load_fill",  32'(fill_d), 0);
    check("t5_load_match", 32'(m_d), 0);
    s5 = 4'b0110;
    m5 = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, s5[3-i]);
      check($sformatf("t5_match_b%0d", i+1), 32'(m_d), 32'(m5[3-i]));
    end
    check("t5_cnt", 32'(cnt_d), 1);

    // Test 6: asynchronous reset mid-stream
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    en = 1'b0;
    check("t6_pre_fill", 32'(fill_d), 4);
    check("t6_pre_cnt",  32'(cnt_d), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_fill", 32'(fill_d), 0);
    check("t6_async_cnt",  32'(cnt_d), 0);
    check("t6_async_match", 32'(m_d), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1);
    check("t6_one_match", 32'(m_d), 0);
    check("t6_one_fill",  32'(fill_d), 1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("t6_b3_match", 32'(m_d), 0);
    step(1'b1, 1'b1);
    check("t6_full_match", 32'(m_d), 1);
    check("t6_cnt",        32'(cnt_d), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
